// File: rtl/iterative_shift_unit_if.sv
// Request/response bundle for iterative_shift_unit: the start/op/operand/amount request
// and the busy/done/result/carry/err response.
interface iterative_shift_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [31:0]      amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             err;

  modport master (
    output start, op, data_in, amount,
    input  busy, done, result, carry, err
  );

  modport slave (
    input  start, op, data_in, amount,
    output busy, done, result, carry, err
  );
endinterface

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shift/rotate unit that moves up to STEP bits per clock behind a start/done handshake.
// Define SHIFT_ROTATE_EN to implement ROR/ROL; without it those opcodes report err.
module iterative_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                 Clock,
  input  logic                 Clear,
  iterative_shift_unit_if.slave io_bus
);
  localparam int AMT_W = $clog2(WIDTH);
  localparam int K_W   = AMT_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  localparam logic [K_W-1:0] STEP_K  = K_W'(STEP);
  localparam logic [K_W-1:0] WIDTH_K = K_W'(WIDTH);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic [AMT_W-1:0] r_rem;
  logic [2:0]       r_op;
  logic             r_sign;
  logic             r_cwork;
  logic             r_carry;
  logic             r_err;

  logic [K_W-1:0]   w_k;
  logic [AMT_W-1:0] w_ridx;
  logic [AMT_W-1:0] w_lidx;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_fill;
  logic [WIDTH-1:0] w_next;
  logic             w_cout;
  logic             w_accept;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
    return (op <= OP_ROL);
`else
    return (op <= OP_SHL);
`endif
  endfunction

  assign w_accept = (r_state != S_RUN) && io_bus.start;

  // One step: shift by k = min(STEP, rem); carry is the last bit to leave the word
  always_comb begin
    w_k    = ({1'b0, r_rem} > STEP_K) ? STEP_K : {1'b0, r_rem};
    w_ridx = AMT_W'(w_k - K_W'(1));
    w_lidx = AMT_W'(WIDTH_K - w_k);
    w_shr  = r_work >> w_k;
    w_shl  = r_work << w_k;
    w_fill = ~({WIDTH{1'b1}} >> w_k);
    w_next = r_work;
    w_cout = r_cwork;
    case (r_op)
      OP_SHR: begin
        w_next = w_shr;
        w_cout = r_work[w_ridx];
      end
      OP_SHRA: begin
        w_next = w_shr | (r_sign ? w_fill : '0);
        w_cout = r_work[w_ridx];
      end
      OP_SHL: begin
        w_next = w_shl;
        w_cout = r_work[w_lidx];
      end
`ifdef SHIFT_ROTATE_EN
      OP_ROR: begin
        w_next = w_shr | (r_work << (WIDTH_K - w_k));
        w_cout = r_work[w_ridx];
      end
      OP_ROL: begin
        w_next = w_shl | (r_work >> (WIDTH_K - w_k));
        w_cout = r_work[w_lidx];
      end
`endif
      default: ;
    endcase
  end

  // Control and visible outputs
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_rem   <= io_bus.amount[AMT_W-1:0];
            r_carry <= 1'b0;
            if (op_legal(io_bus.op)) begin
              r_err   <= 1'b0;
              r_state <= S_RUN;
            end else begin
              r_err    <= 1'b1;
              r_result <= io_bus.data_in;
              r_state  <= S_DONE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (r_rem == '0) begin
            r_state  <= S_DONE;
            r_result <= r_work;
            r_carry  <= r_cwork;
          end else begin
            r_rem <= r_rem - AMT_W'(w_k);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Working datapath; only meaningful between acceptance and completion
  always_ff @(posedge Clock) begin
    if (w_accept) begin
      r_work  <= io_bus.data_in;
      r_op    <= io_bus.op;
      r_sign  <= io_bus.data_in[WIDTH-1];
      r_cwork <= 1'b0;
    end else if (r_state == S_RUN && r_rem != '0) begin
      r_work  <= w_next;
      r_cwork <= w_cout;
    end
  end

  assign io_bus.busy   = (r_state == S_RUN);
  assign io_bus.done   = (r_state == S_DONE);
  assign io_bus.result = r_result;
  assign io_bus.carry  = r_carry;
  assign io_bus.err    = r_err;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench driving a STEP=1 and a STEP=4 instance of iterative_shift_unit with the same requests.
module tb_iterative_shift_unit;
  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] din = '0;
  logic [31:0] amt = '0;

  int n_cmp = 0;
  int n_err = 0;

  int          lat1, lat4, bc1, bc4;
  logic [31:0] res1, res4;
  logic        car1, car4, err1, err4;

  iterative_shift_unit_if #(.WIDTH(32)) b1 ();
  iterative_shift_unit_if #(.WIDTH(32)) b4 ();

  assign b1.start = start;  assign b1.op = op;  assign b1.data_in = din;  assign b1.amount = amt;
  assign b4.start = start;  assign b4.op = op;  assign b4.data_in = din;  assign b4.amount = amt;

  iterative_shift_unit #(.WIDTH(32), .STEP(1)) dut1 (.Clock(clk), .Clear(clear), .io_bus(b1.slave));
  iterative_shift_unit #(.WIDTH(32), .STEP(4)) dut4 (.Clock(clk), .Clear(clear), .io_bus(b4.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy1"}, 32'(b1.busy), 0);   chk({tag, "_done1"}, 32'(b1.done), 0);
    chk({tag, "_res1"},  b1.result, 0);      chk({tag, "_car1"},  32'(b1.carry), 0);
    chk({tag, "_err1"},  32'(b1.err), 0);
    chk({tag, "_busy4"}, 32'(b4.busy), 0);   chk({tag, "_done4"}, 32'(b4.done), 0);
    chk({tag, "_res4"},  b4.result, 0);      chk({tag, "_car4"},  32'(b4.carry), 0);
    chk({tag, "_err4"},  32'(b4.err), 0);
  endtask

  // Launch one request, optionally pulse start again at loop index pulse_at, record both completions
  task automatic run(input logic [2:0] o, input logic [31:0] d, input logic [31:0] a, input int pulse_at);
    @(negedge clk);
    start = 1'b1; op = o; din = d; amt = a;
    @(posedge clk);
    #1 start = 1'b0;
    lat1 = 999; lat4 = 999; bc1 = 0; bc4 = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      start = (n == pulse_at);
      if (n == pulse_at) begin op = 3'd2; din = 32'hFFFF_FFFF; amt = 32'd3; end
      if (b1.busy) bc1++;
      if (b4.busy) bc4++;
      if (b1.done && lat1 == 999) begin lat1 = n; res1 = b1.result; car1 = b1.carry; err1 = b1.err; end
      if (b4.done && lat4 == 999) begin lat4 = n; res4 = b4.result; car4 = b4.carry; err4 = b4.err; end
      if (lat1 != 999 && lat4 != 999) break;
    end
    start = 1'b0;
  endtask

  task automatic expect_op(input string tag, input logic [31:0] r, input logic c, input logic e,
                           input int l1, input int l4);
    chk({tag, "_lat1"}, 32'(lat1), 32'(l1));  chk({tag, "_res1"}, res1, r);
    chk({tag, "_car1"}, 32'(car1), 32'(c));   chk({tag, "_err1"}, 32'(err1), 32'(e));
    chk({tag, "_lat4"}, 32'(lat4), 32'(l4));  chk({tag, "_res4"}, res4, r);
    chk({tag, "_car4"}, 32'(car4), 32'(c));   chk({tag, "_err4"}, 32'(err4), 32'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_idle_zero("reset");
    @(negedge clk) clear = 1'b1;

    run(3'd1, 32'h8000_0012, 32'd4, -1);
    expect_op("shra4", 32'hF800_0001, 1'b0, 1'b0, 5, 2);
    run(3'd1, 32'h8000_0012, 32'd5, -1);
    expect_op("shra5", 32'hFC00_0000, 1'b1, 1'b0, 6, 3);

    run(3'd2, 32'h0000_0001, 32'd31, -1);
    expect_op("shl31", 32'h8000_0000, 1'b0, 1'b0, 32, 9);
    chk("shl31_busy1", 32'(bc1), 32);
    chk("shl31_busy4", 32'(bc4), 9);

`ifdef SHIFT_ROTATE_EN
    run(3'd3, 32'h0000_0018, 32'd4, -1);
    expect_op("ror4", 32'h8000_0001, 1'b1, 1'b0, 5, 2);
    run(3'd4, 32'h8000_0001, 32'd1, -1);
    expect_op("rol1", 32'h0000_0003, 1'b1, 1'b0, 2, 2);
`else
    run(3'd3, 32'h0000_0018, 32'd4, -1);
    expect_op("ror_off", 32'h0000_0018, 1'b0, 1'b1, 0, 0);
    chk("ror_off_busy1", 32'(bc1), 0);
    chk("ror_off_busy4", 32'(bc4), 0);
`endif

    run(3'd7, 32'hDEAD_BEEF, 32'd3, -1);
    expect_op("illegal", 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 0);
    chk("illegal_busy1", 32'(bc1), 0);

    run(3'd2, 32'h8000_0001, 32'd1, -1);
    expect_op("shl1", 32'h0000_0002, 1'b1, 1'b0, 2, 2);

    run(3'd0, 32'hF000_0000, 32'd36, -1);
    expect_op("shr36", 32'h0F00_0000, 1'b0, 1'b0, 5, 2);
    run(3'd0, 32'hF000_0000, 32'd32, -1);
    expect_op("shr32", 32'hF000_0000, 1'b0, 1'b0, 1, 1);

    run(3'd0, 32'h0000_0180, 32'd8, 1);
    expect_op("ignore", 32'h0000_0001, 1'b1, 1'b0, 9, 3);

    repeat (3) @(negedge clk);
    chk("held_res1", b1.result, 32'h0000_0001);
    chk("held_done1", 32'(b1.done), 0);
    chk("held_car4", 32'(b4.carry), 1);

    // Back-to-back: start held high through RUN and into DONE
    @(negedge clk);
    start = 1'b1; op = 3'd0; din = 32'h0000_0008; amt = 32'd1;
    @(posedge clk);
    #1 din = 32'h0000_0042; amt = 32'd2;
    @(negedge clk);
    chk("b2b_busy1", 32'(b1.busy), 1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_a_done1", 32'(b1.done), 1);
    chk("b2b_a_res1", b1.result, 32'h0000_0004);
    chk("b2b_a_done4", 32'(b4.done), 1);
    chk("b2b_a_res4", b4.result, 32'h0000_0004);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_b_busy1", 32'(b1.busy), 1);
    chk("b2b_b_busy4", 32'(b4.busy), 1);
    chk("b2b_b_done1", 32'(b1.done), 0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_b_done4", 32'(b4.done), 1);
    chk("b2b_b_res4", b4.result, 32'h0000_0010);
    chk("b2b_b_car4", 32'(b4.carry), 1);
    chk("b2b_b_early1", 32'(b1.done), 0);
    @(negedge clk);
    chk("b2b_b_done1", 32'(b1.done), 1);
    chk("b2b_b_res1", b1.result, 32'h0000_0010);
    chk("b2b_b_car1", 32'(b1.carry), 1);

    // Reset in the middle of a long operation
    @(negedge clk);
    start = 1'b1; op = 3'd2; din = 32'h0000_0001; amt = 32'd20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    @(posedge clk);
    #1 chk_idle_zero("midreset");
    @(negedge clk) clear = 1'b1;
    dcount = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (b1.done || b4.done || b1.busy || b4.busy) dcount++;
    end
    chk("midreset_quiet", 32'(dcount), 0);

    run(3'd2, 32'h0000_0001, 32'd3, -1);
    expect_op("postreset", 32'h0000_0008, 1'b0, 1'b0, 4, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
